// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient loader.
// Holds the coefficient width, the loader FSM state encoding and the
// derivation of the B-cascade chain length from samples per clock.
package biquad_pkg;

  localparam int COEFF_W = 18;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_FLUSH  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Number of coefficient registers in the B-cascade chain for a given
  // number of samples per clock.
  function automatic int ncoeff_of(input int nsamp);
    return 2 * (nsamp - 2);
  endfunction

endpackage

// File: rtl/biquad_coeff_loader.sv
// Stages biquad coefficients and streams them into the filter's B1 chain, then pulses B1->B2 update.
// Latency: commit at cycle C -> shifts C+1..C+N, data C+2..C+N+1, update C+N+2, done C+N+3.
// Backpressure: writes while busy are rejected with err_o; commits while busy merge into one pending reload.
module biquad_coeff_loader
  import biquad_pkg::*;
#(
  parameter int NSAMP  = 8,
  parameter int NCOEFF = ncoeff_of(NSAMP),
  parameter int AW     = $clog2(NCOEFF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_i,
  input  logic [AW-1:0]             addr_i,
  input  logic signed [COEFF_W-1:0] dat_i,
  input  logic                      commit_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic signed [COEFF_W-1:0] coeff_dat_o,
  output logic                      coeff_wr_o,
  output logic                      coeff_update_o
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [AW-1:0]               r_cnt;
  logic                        r_pend;
  logic                        r_err;
  logic signed [COEFF_W-1:0]   r_dat;
  logic signed [COEFF_W-1:0]   r_stage [NCOEFF];

  logic                        w_busy;
  logic                        w_addr_ok;
  logic                        w_wr_ok;
  logic [AW-1:0]               w_rd_idx;
  logic                        w_last_shift;

  assign w_addr_ok    = (32'(addr_i) < NCOEFF);
  assign w_wr_ok      = wr_i && !w_busy && w_addr_ok;
  // Farthest chain register goes out first so it ends up deepest in B1.
  assign w_rd_idx     = AW'(NCOEFF - 1) - r_cnt;
  assign w_last_shift = (r_cnt == AW'(NCOEFF - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and control outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy         = 1'b1;
    coeff_wr_o     = 1'b0;
    coeff_update_o = 1'b0;
    done_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (commit_i) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        coeff_wr_o = 1'b1;
        if (w_last_shift) w_state_nxt = S_FLUSH;
      end
      // Lets the last coefficient land: the filter registers its shift enable.
      S_FLUSH:  w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        coeff_update_o = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        // A commit in this very cycle is also a busy-time commit and chains.
        w_state_nxt = (r_pend || commit_i) ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy_o      = w_busy;
  assign err_o       = r_err;
  assign coeff_dat_o = r_dat;

  // Shift counter: runs only during SHIFT, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == S_SHIFT) r_cnt <= r_cnt + AW'(1);
    else                        r_cnt <= '0;
  end

  // Pending reload: merges all commits seen while busy, consumed on DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_pend <= 1'b0;
    else if (r_state == S_DONE) r_pend <= 1'b0;
    else if (w_busy && commit_i) r_pend <= 1'b1;
  end

  // Reject pulse for out-of-range or busy-time writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= wr_i && (w_busy || !w_addr_ok);
  end

  // Outgoing coefficient register; holds its value outside SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_dat <= '0;
    else if (r_state == S_SHIFT) r_dat <= r_stage[w_rd_idx];
  end

  // Staging buffer; a load only reads it, so a re-commit resends the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCOEFF; k++) r_stage[k] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < NCOEFF; k++) begin
        if (32'(addr_i) == k) r_stage[k] <= dat_i;
      end
    end
  end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Directed bench for biquad_coeff_loader with NSAMP=8 (12 coefficients).
// Models the downstream B1 shift chain (registered shift enable) and B2 bank.
module tb_biquad_coeff_loader;

  localparam int N = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [17:0] dat_i = '0;
  logic        commit_i = 1'b0;
  logic        busy_o, done_o, err_o, coeff_wr_o, coeff_update_o;
  logic [17:0] coeff_dat_o;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;

  logic [17:0] exp_stage [N];
  logic [17:0] b1 [N];
  logic [17:0] b2 [N];
  logic        ce_q = 1'b0;

  biquad_coeff_loader #(.NSAMP(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_i           (wr_i),
    .addr_i         (addr_i),
    .dat_i          (dat_i),
    .commit_i       (commit_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .coeff_dat_o    (coeff_dat_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o)
  );

  always #5 clk = ~clk;

  // Downstream filter model: registered CE shifts B1 toward index N-1.
  always @(posedge clk) begin
    ce_q <= coeff_wr_o;
    if (ce_q) begin
      for (int j = N - 1; j > 0; j--) b1[j] <= b1[j-1];
      b1[0] <= coeff_dat_o;
    end
    if (coeff_update_o) begin
      for (int j = 0; j < N; j++) b2[j] <= b1[j];
      upd_cnt <= upd_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int k, input logic [17:0] v);
    wr_i = 1'b1; addr_i = 4'(k); dat_i = v;
    step();
    wr_i = 1'b0;
  endtask

  task automatic check_b2(input string nm);
    for (int j = 0; j < N; j++) begin
      tests++;
      if (b2[j] !== exp_stage[j]) begin
        fails++;
        $display("FAIL %s b2[%0d] got %h want %h", nm, j, b2[j], exp_stage[j]);
      end
    end
  endtask

  // Called in cycle C+1; checks every cycle through C+15 (DONE) and stops there.
  // Optionally injects a busy-time write at wr_at and commits at c1/c2.
  task automatic watch_seq(input string nm, input int wr_at, input int c1, input int c2);
    logic [4:0]  exp_ctl, got_ctl;
    logic [17:0] exp_d;
    for (int t = 1; t <= 15; t++) begin
      wr_i = 1'b0; commit_i = 1'b0;
      exp_ctl = {1'b1, t <= 12, t == 14, t == 15, (wr_at != 0) && (t == wr_at + 1)};
      got_ctl = {busy_o, coeff_wr_o, coeff_update_o, done_o, err_o};
      tests++;
      if (got_ctl !== exp_ctl) begin
        fails++;
        $display("FAIL %s ctl t=%0d got %b want %b (busy,wr,upd,done,err)", nm, t, got_ctl, exp_ctl);
      end
      if (t >= 2 && t <= 14) begin
        exp_d = exp_stage[(t <= 13) ? 13 - t : 0];
        tests++;
        if (coeff_dat_o !== exp_d) begin
          fails++;
          $display("FAIL %s dat t=%0d got %h want %h", nm, t, coeff_dat_o, exp_d);
        end
      end
      if (t < 15) begin
        if (t == wr_at) begin wr_i = 1'b1; addr_i = 4'd3; dat_i = 18'h3FFFF; end
        if (t == c1 || t == c2) commit_i = 1'b1;
        step();
      end
    end
  endtask

  task automatic check_idle(input string nm);
    tests++;
    if ({busy_o, coeff_wr_o, coeff_update_o, done_o} !== 4'b0000) begin
      fails++;
      $display("FAIL %s idle got %b want 0000", nm, {busy_o, coeff_wr_o, coeff_update_o, done_o});
    end
    tests++;
    if (coeff_dat_o !== exp_stage[0]) begin
      fails++;
      $display("FAIL %s dat hold got %h want %h", nm, coeff_dat_o, exp_stage[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++;
    if ({busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_dat_o} !== 23'd0) begin
      fails++;
      $display("FAIL reset outputs got %b want 0", {busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_dat_o});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    for (int k = 0; k < N; k++) begin
      exp_stage[k] = 18'h100 + 18'(k);
      write(k, exp_stage[k]);
    end
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL load err got %b want 0", err_o);
    end
    commit_i = 1'b1;
    step();
    watch_seq("load", 0, 0, 0);
    step();
    check_idle("load");
    check_b2("load");
  endtask

  task automatic test_bad_addr();
    write(12, 18'h3FFFF);
    tests++;
    if (err_o !== 1'b1) begin
      fails++;
      $display("FAIL bad_addr err got %b want 1", err_o);
    end
    step();
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL bad_addr err_clear got %b want 0", err_o);
    end
    commit_i = 1'b1;
    step();
    watch_seq("bad_addr", 0, 0, 0);
    step();
    check_b2("bad_addr");
  endtask

  task automatic test_write_with_commit();
    wr_i = 1'b1; addr_i = 4'd0; dat_i = 18'h0AA; commit_i = 1'b1;
    exp_stage[0] = 18'h0AA;
    step();
    watch_seq("wr_commit", 0, 0, 0);
    step();
    check_idle("wr_commit");
    check_b2("wr_commit");
  endtask

  task automatic test_busy_write();
    commit_i = 1'b1;
    step();
    watch_seq("busy_wr", 5, 0, 0);
    step();
    check_idle("busy_wr");
    check_b2("busy_wr");
  endtask

  task automatic test_back_to_back();
    int u0;
    u0 = upd_cnt;
    commit_i = 1'b1;
    step();
    watch_seq("b2b_first", 0, 3, 7);
    step();
    watch_seq("b2b_second", 0, 0, 0);
    step();
    check_idle("b2b");
    tests++;
    if (upd_cnt - u0 !== 2) begin
      fails++;
      $display("FAIL b2b update_count got %0d want 2", upd_cnt - u0);
    end
    check_b2("b2b");
  endtask

  task automatic test_reset_mid();
    int u0;
    logic [17:0] saved [N];
    for (int j = 0; j < N; j++) saved[j] = b2[j];
    u0 = upd_cnt;
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    repeat (5) step();
    tests++;
    if (coeff_wr_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid pre wr got %b want 1", coeff_wr_o);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_dat_o} !== 23'd0) begin
      fails++;
      $display("FAIL rst_mid async outputs got %b want 0", {busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_dat_o});
    end
    step();
    rst = 1'b0;
    repeat (12) step();
    tests++;
    if (upd_cnt !== u0) begin
      fails++;
      $display("FAIL rst_mid update_count got %0d want %0d", upd_cnt, u0);
    end
    for (int j = 0; j < N; j++) begin
      tests++;
      if (b2[j] !== saved[j]) begin
        fails++;
        $display("FAIL rst_mid b2_kept[%0d] got %h want %h", j, b2[j], saved[j]);
      end
    end
    // Staging was cleared by reset, so the next full load sends zeros.
    for (int k = 0; k < N; k++) exp_stage[k] = '0;
    commit_i = 1'b1;
    step();
    watch_seq("rst_reload", 0, 0, 0);
    step();
    check_idle("rst_reload");
    check_b2("rst_reload");
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_addr();
    test_write_with_commit();
    test_busy_write();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
